// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of the 5-stage pipeline. It sits directly downstream of
// the EX/MEM barrier. Loads and stores run over a req/ready data-memory
// handshake, and the stage holds the upstream pipeline while an access is
// outstanding. Results are registered into WB, so the MEM/WB register is built
// into this module. Non-memory ops pass through with one cycle of latency.
//
// Configuration macro:
//   MEM_MISALIGN_CHECK_EN
//     Defined:   an access whose address has bits [1:0] != 0 is dropped.
//                It is not issued, and memMisaligned pulses for one cycle.
//     Undefined: there is no alignment check, and memMisaligned is tied to 0.
//
// Parameters:
//   DATA_WIDTH       data / ALU result width
//   REG_INDEX_WIDTH  register index width
//   TIMEOUT_CYCLES   maximum number of ACCESS cycles spent waiting on
//                    dmemReady; 0 disables the timeout
//
// Ports:
//   clk, reset                  rising-edge clock; asynchronous active-high reset
//   memAluResult                address (load/store) or ALU result from EX/MEM
//   memMemoryWriteData          store data from EX/MEM
//   memWriteRegisterIndex       destination register from EX/MEM
//   memMemWrite                 store flag
//   memMemToReg                 load flag
//   memRegWrite                 register-write flag
//   memStall                    combinational; holds PC/IF/ID/EX and EX/MEM
//   dmemReq                     registered memory request
//   dmemWe                      memory write enable (1 = write, 0 = read)
//   dmemAddr                    memory byte address
//   dmemWriteData               memory store data
//   dmemReady, dmemReadData     memory completion handshake and load data
//   wbResult                    result to WB
//   wbWriteRegisterIndex        destination register to WB
//   wbRegWrite                  register-write enable to WB
//   memTimeout                  sticky flag: an access timed out
//   memMisaligned               one-cycle pulse: a misaligned access was dropped
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_INDEX_WIDTH = 5,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      memAluResult,
  input  logic [DATA_WIDTH-1:0]      memMemoryWriteData,
  input  logic [REG_INDEX_WIDTH-1:0] memWriteRegisterIndex,
  input  logic                       memMemWrite,
  input  logic                       memMemToReg,
  input  logic                       memRegWrite,
  output logic                       memStall,
  output logic                       dmemReq,
  output logic                       dmemWe,
  output logic [DATA_WIDTH-1:0]      dmemAddr,
  output logic [DATA_WIDTH-1:0]      dmemWriteData,
  input  logic                       dmemReady,
  input  logic [DATA_WIDTH-1:0]      dmemReadData,
  output logic [DATA_WIDTH-1:0]      wbResult,
  output logic [REG_INDEX_WIDTH-1:0] wbWriteRegisterIndex,
  output logic                       wbRegWrite,
  output logic                       memTimeout,
  output logic                       memMisaligned
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  // The counter keeps at least one bit so the design still elaborates when the
  // timeout is disabled.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [0:0]                 state;
  logic [CNT_W-1:0]           counter;
  logic                       cap_load;
  logic                       cap_reg_write;
  logic [REG_INDEX_WIDTH-1:0] cap_index;

  logic is_access;
  logic misaligned;
  logic issue;
  logic timeout_hit;

  // Decode the EX/MEM request and detect the last cycle before a timeout.
  always_comb begin
    is_access = memMemWrite | memMemToReg;
`ifdef MEM_MISALIGN_CHECK_EN
    misaligned = is_access & (memAluResult[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    issue       = is_access & ~misaligned;
    timeout_hit = TIMEOUT_EN & (counter == CNT_LAST) & ~dmemReady;
  end

  // Stall generation. The stall drops in the completion cycle so that upstream
  // advances on the same edge that retires the access.
  always_comb begin
    memStall = 1'b0;
    case (state)
      IDLE:    memStall = issue;
      ACCESS:  memStall = ~(dmemReady | timeout_hit);
      default: memStall = 1'b0;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // One-cycle pulse that flags a misaligned access dropped in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memMisaligned <= 1'b0;
    end else begin
      memMisaligned <= (state == IDLE) & misaligned;
    end
  end
`else
  assign memMisaligned = 1'b0;
`endif

  // Main FSM: memory handshake, MEM/WB register and timeout tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      counter              <= {CNT_W{1'b0}};
      cap_load             <= 1'b0;
      cap_reg_write        <= 1'b0;
      cap_index            <= {REG_INDEX_WIDTH{1'b0}};
      dmemReq              <= 1'b0;
      dmemWe               <= 1'b0;
      dmemAddr             <= {DATA_WIDTH{1'b0}};
      dmemWriteData        <= {DATA_WIDTH{1'b0}};
      wbResult             <= {DATA_WIDTH{1'b0}};
      wbWriteRegisterIndex <= {REG_INDEX_WIDTH{1'b0}};
      wbRegWrite           <= 1'b0;
      memTimeout           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            // When both load and store are set, the op is treated as a store,
            // so the captured result is the address.
            cap_load      <= memMemToReg & ~memMemWrite;
            cap_reg_write <= memRegWrite;
            cap_index     <= memWriteRegisterIndex;
            dmemReq       <= 1'b1;
            dmemWe        <= memMemWrite;
            dmemAddr      <= memAluResult;
            dmemWriteData <= memMemoryWriteData;
            counter       <= {CNT_W{1'b0}};
            wbRegWrite    <= 1'b0;
            state         <= ACCESS;
          end else if (misaligned) begin
            wbRegWrite <= 1'b0;
          end else begin
            wbResult             <= memAluResult;
            wbWriteRegisterIndex <= memWriteRegisterIndex;
            wbRegWrite           <= memRegWrite;
          end
        end
        ACCESS: begin
          if (dmemReady) begin
            // Ready has priority over a timeout in the same cycle.
            dmemReq              <= 1'b0;
            wbResult             <= cap_load ? dmemReadData : dmemAddr;
            wbWriteRegisterIndex <= cap_index;
            wbRegWrite           <= cap_reg_write;
            state                <= IDLE;
          end else if (timeout_hit) begin
            dmemReq    <= 1'b0;
            memTimeout <= 1'b1;
            wbRegWrite <= 1'b0;
            state      <= IDLE;
          end else begin
            // The counter saturates instead of wrapping.
            if (counter != CNT_MAX) begin
              counter <= counter + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              counter <= counter;
            end
            wbRegWrite <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          dmemReq    <= 1'b0;
          wbRegWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed, self-checking bench for mem_access_stage.
// The DUT is built with TIMEOUT_CYCLES = 4.
// Inputs are driven on the falling edge, and outputs are sampled on the falling
// edge, away from the rising clock edge.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memAluResult;
  logic [31:0] memMemoryWriteData;
  logic [4:0]  memWriteRegisterIndex;
  logic        memMemWrite;
  logic        memMemToReg;
  logic        memRegWrite;
  logic        memStall;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWriteData;
  logic        dmemReady;
  logic [31:0] dmemReadData;
  logic [31:0] wbResult;
  logic [4:0]  wbWriteRegisterIndex;
  logic        wbRegWrite;
  logic        memTimeout;
  logic        memMisaligned;

  int tests_run    = 0;
  int tests_failed = 0;
  int stall_count;

  mem_access_stage #(
    .DATA_WIDTH      (32),
    .REG_INDEX_WIDTH (5),
    .TIMEOUT_CYCLES  (4)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .memAluResult          (memAluResult),
    .memMemoryWriteData    (memMemoryWriteData),
    .memWriteRegisterIndex (memWriteRegisterIndex),
    .memMemWrite           (memMemWrite),
    .memMemToReg           (memMemToReg),
    .memRegWrite           (memRegWrite),
    .memStall              (memStall),
    .dmemReq               (dmemReq),
    .dmemWe                (dmemWe),
    .dmemAddr              (dmemAddr),
    .dmemWriteData         (dmemWriteData),
    .dmemReady             (dmemReady),
    .dmemReadData          (dmemReadData),
    .wbResult              (wbResult),
    .wbWriteRegisterIndex  (wbWriteRegisterIndex),
    .wbRegWrite            (wbRegWrite),
    .memTimeout            (memTimeout),
    .memMisaligned         (memMisaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] idx,
                       input logic we, input logic ld, input logic rw);
    memAluResult          = addr;
    memMemoryWriteData    = wdata;
    memWriteRegisterIndex = idx;
    memMemWrite           = we;
    memMemToReg           = ld;
    memRegWrite           = rw;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance to the next falling edge, where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    dmemReady    = 1'b0;
    dmemReadData = 32'h0;
    nop();
    @(negedge clk);
    @(negedge clk);
    check("rst_req",     {31'b0, dmemReq},    32'h0);
    check("rst_wbres",   wbResult,            32'h0);
    check("rst_wbrw",    {31'b0, wbRegWrite}, 32'h0);
    check("rst_timeout", {31'b0, memTimeout}, 32'h0);
    check("rst_stall",   {31'b0, memStall},   32'h0);
    reset = 1'b0;

    // ALU op: one-cycle pass-through, no stall.
    drive(32'h10, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1);
    #1 check("alu_stall", {31'b0, memStall}, 32'h0);
    step();
    check("alu_wbres", wbResult,                     32'h10);
    check("alu_wbidx", {27'b0, wbWriteRegisterIndex}, 32'd3);
    check("alu_wbrw",  {31'b0, wbRegWrite},           32'h1);
    check("alu_req",   {31'b0, dmemReq},              32'h0);

    // Load at 0x100; ready arrives on the 3rd ACCESS cycle, so stall is high 3 cycles.
    drive(32'h100, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1);
    stall_count = 0;
    #1 if (memStall) stall_count++;
    step();
    check("ld_req", {31'b0, dmemReq}, 32'h1);
    check("ld_we",  {31'b0, dmemWe},  32'h0);
    check("ld_addr", dmemAddr,        32'h100);
    check("ld_bubble", {31'b0, wbRegWrite}, 32'h0);
    if (memStall) stall_count++;
    step();
    if (memStall) stall_count++;
    step();
    dmemReady    = 1'b1;
    dmemReadData = 32'hDEADBEEF;
    #1 if (memStall) stall_count++;
    check("ld_stall_cnt", stall_count, 32'd3);
    step();
    dmemReady = 1'b0;
    check("ld_wbres", wbResult,                      32'hDEADBEEF);
    check("ld_wbidx", {27'b0, wbWriteRegisterIndex}, 32'd5);
    check("ld_wbrw",  {31'b0, wbRegWrite},           32'h1);
    check("ld_req_drop", {31'b0, dmemReq},           32'h0);
    nop();

    // Store at 0x200 with data 0x1234; address and data stay stable until ready.
    drive(32'h200, 32'h1234, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("st_req",   {31'b0, dmemReq}, 32'h1);
      check("st_we",    {31'b0, dmemWe},  32'h1);
      check("st_addr",  dmemAddr,         32'h200);
      check("st_wdata", dmemWriteData,    32'h1234);
    end
    dmemReady = 1'b1;
    step();
    dmemReady = 1'b0;
    nop();
    check("st_wbrw", {31'b0, wbRegWrite}, 32'h0);
    check("st_req_drop", {31'b0, dmemReq}, 32'h0);

    // Ready while no request is outstanding is ignored: the ALU op passes through.
    drive(32'h77, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1);
    dmemReady    = 1'b1;
    dmemReadData = 32'hFFFF0000;
    step();
    dmemReady = 1'b0;
    check("idle_rdy_wbres", wbResult, 32'h77);
    nop();

    // Load with no ready: the request is held for 4 cycles, then the access times out.
    drive(32'h300, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1);
    stall_count = 0;
    for (int k = 1; k <= 20 && stall_count < 4; k++) begin
      step();
      if (dmemReq) stall_count++;
      if (stall_count == 4) begin
        #1 check("to_last_stall", {31'b0, memStall}, 32'h0);
        nop();
      end
    end
    check("to_req_cycles", stall_count, 32'd4);
    step();
    check("to_req_drop", {31'b0, dmemReq},    32'h0);
    check("to_flag",     {31'b0, memTimeout}, 32'h1);
    check("to_wbrw",     {31'b0, wbRegWrite}, 32'h0);
    step();
    check("to_sticky", {31'b0, memTimeout}, 32'h1);

    // Load and store both set: treated as a store; the result is the address.
    drive(32'h400, 32'h55, 5'd4, 1'b1, 1'b1, 1'b1);
    step();
    check("both_we", {31'b0, dmemWe}, 32'h1);
    dmemReady    = 1'b1;
    dmemReadData = 32'hAAAA;
    #1 check("both_stall", {31'b0, memStall}, 32'h0);
    step();
    dmemReady = 1'b0;
    nop();
    check("both_wbres", wbResult,           32'h400);
    check("both_wbrw",  {31'b0, wbRegWrite}, 32'h1);

    // Reset asserted mid-ACCESS; afterwards an ALU op flows normally.
    drive(32'h500, 32'h0, 5'd2, 1'b0, 1'b1, 1'b1);
    step();
    check("mid_req", {31'b0, dmemReq}, 32'h1);
    nop();
    #2 reset = 1'b1;
    #1 check("mid_rst_req",   {31'b0, dmemReq},    32'h0);
    check("mid_rst_stall",   {31'b0, memStall},   32'h0);
    check("mid_rst_timeout", {31'b0, memTimeout}, 32'h0);
    check("mid_rst_wbres",   wbResult,            32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'h44, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1);
    step();
    nop();
    check("post_rst_wbres", wbResult,                      32'h44);
    check("post_rst_wbidx", {27'b0, wbWriteRegisterIndex}, 32'd7);
    check("post_rst_wbrw",  {31'b0, wbRegWrite},           32'h1);

    // Misaligned load at 0x102.
    drive(32'h102, 32'h0, 5'd8, 1'b0, 1'b1, 1'b1);
`ifdef MEM_MISALIGN_CHECK_EN
    #1 check("mis_stall", {31'b0, memStall}, 32'h0);
    step();
    nop();
    check("mis_req",   {31'b0, dmemReq},       32'h0);
    check("mis_pulse", {31'b0, memMisaligned}, 32'h1);
    check("mis_wbrw",  {31'b0, wbRegWrite},    32'h0);
    step();
    check("mis_pulse_end", {31'b0, memMisaligned}, 32'h0);
`else
    #1 check("mis_stall", {31'b0, memStall}, 32'h1);
    step();
    check("mis_req",  {31'b0, dmemReq},       32'h1);
    check("mis_addr", dmemAddr,               32'h102);
    check("mis_flag", {31'b0, memMisaligned}, 32'h0);
    dmemReady    = 1'b1;
    dmemReadData = 32'hCAFE;
    step();
    dmemReady = 1'b0;
    nop();
    check("mis_wbres", wbResult, 32'hCAFE);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
